// File: rtl/jelly2_mipi_csi2_pkg.sv
// Shared CSI-2 RAW definitions: data type codes, the internal format enum and
// per-format geometry helpers used by the unpacker and its extractor.
package jelly2_mipi_csi2_pkg;

  localparam logic [7:0] DT_RAW8  = 8'h2a;
  localparam logic [7:0] DT_RAW10 = 8'h2b;
  localparam logic [7:0] DT_RAW12 = 8'h2c;
  localparam logic [7:0] DT_RAW14 = 8'h2d;

  typedef enum logic [1:0] {
    FMT_RAW8  = 2'd0,
    FMT_RAW10 = 2'd1,
    FMT_RAW12 = 2'd2,
    FMT_RAW14 = 2'd3
  } fmt_t;

  function automatic logic [2:0] fmt_pixels(input fmt_t f);
    case (f)
      FMT_RAW8:  return 3'd1;
      FMT_RAW10: return 3'd4;
      FMT_RAW12: return 3'd2;
      FMT_RAW14: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] fmt_bytes(input fmt_t f);
    case (f)
      FMT_RAW8:  return 3'd1;
      FMT_RAW10: return 3'd5;
      FMT_RAW12: return 3'd3;
      FMT_RAW14: return 3'd7;
      default:   return 3'd1;
    endcase
  endfunction

  function automatic logic [4:0] fmt_depth(input fmt_t f);
    case (f)
      FMT_RAW8:  return 5'd8;
      FMT_RAW10: return 5'd10;
      FMT_RAW12: return 5'd12;
      FMT_RAW14: return 5'd14;
      default:   return 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/jelly2_mipi_csi2_raw_extract.sv
// Combinational RAW group extractor: MSB bytes + LSB bytes -> right-aligned
// raw pixels of the selected format (unused pixel slots are zero).
module jelly2_mipi_csi2_raw_extract
  import jelly2_mipi_csi2_pkg::*;
(
  input  fmt_t              fmt,
  input  logic [3:0][7:0]   msb,
  input  logic [2:0][7:0]   lsb,
  output logic [3:0][13:0]  pix
);

  // Reassemble each pixel from its MSB byte and its slice of the LSB bytes
  always_comb begin
    pix = '0;
    case (fmt)
      FMT_RAW8: begin
        pix[0] = {6'd0, msb[0]};
      end
      FMT_RAW10: begin
        for (int k = 0; k < 4; k++) begin
          pix[k] = {4'd0, msb[k], lsb[0][2*k +: 2]};
        end
      end
      FMT_RAW12: begin
        pix[0] = {2'd0, msb[0], lsb[0][3:0]};
        pix[1] = {2'd0, msb[1], lsb[0][7:4]};
      end
      FMT_RAW14: begin
        pix[0] = {msb[0], lsb[0][5:0]};
        pix[1] = {msb[1], lsb[1][3:0], lsb[0][7:6]};
        pix[2] = {msb[2], lsb[2][1:0], lsb[1][7:4]};
        pix[3] = {msb[3], lsb[2][7:2]};
      end
      default: begin
        pix = '0;
      end
    endcase
  end

endmodule

// File: rtl/jelly2_mipi_csi2_rx_raw_unpack.sv
// CSI-2 RAW8/10/12/14 unpacker: byte stream in, one MSB-aligned pixel per beat
// out, with a collect stage feeding a P-pixel drain stage.
module jelly2_mipi_csi2_rx_raw_unpack
  import jelly2_mipi_csi2_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter bit ENABLE_RAW8  = 1'b1,
  parameter bit ENABLE_RAW10 = 1'b1,
  parameter bit ENABLE_RAW12 = 1'b1,
  parameter bit ENABLE_RAW14 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [7:0]            param_data_type,
  output logic                  out_error_short,
  output logic                  out_error_unsupported,
  input  logic                  s_axi4s_tuser,
  input  logic                  s_axi4s_tlast,
  input  logic [7:0]            s_axi4s_tdata,
  input  logic                  s_axi4s_tvalid,
  output logic                  s_axi4s_tready,
  output logic                  m_axi4s_tuser,
  output logic                  m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                  m_axi4s_tvalid,
  input  logic                  m_axi4s_tready
);

  function automatic logic [DATA_WIDTH-1:0] scale_pixel(input logic [13:0] px, input fmt_t f);
    logic [27:0] rep;
    int          depth;
    depth = int'(fmt_depth(f));
    rep   = {14'd0, px} | ({14'd0, px} << depth);
    return DATA_WIDTH'(rep >> (2 * depth - DATA_WIDTH));
  endfunction

  fmt_t                          fmt_q, fmt_d, new_fmt_s, eff_fmt_s;
  logic                          unsup_q, unsup_d, new_unsup_s, eff_unsup_s;
  logic                          run_q;
  logic [2:0]                    cnt_q, cnt_d, eff_cnt_s;
  logic [3:0][7:0]               msb_q, msb_d, msb_n_s;
  logic [2:0][7:0]               lsb_q, lsb_d, lsb_n_s;
  logic [1:0]                    lidx_s;
  logic                          guser_q, guser_d, guser_n_s;
  logic [3:0][DATA_WIDTH-1:0]    pix_q, pix_d;
  logic [2:0]                    dcnt_q, dcnt_d;
  logic                          duser_q, duser_d, dlast_q, dlast_d;
  logic                          err_short_q, err_short_d, err_unsup_q, err_unsup_d;
  logic                          last_byte_s, complete_s, xfer_ok_s, accept_s, m_hs_s;
  logic [3:0][13:0]              raw_s;

  // Decode the run-time data type; disabled formats count as unsupported
  always_comb begin
    new_fmt_s   = FMT_RAW8;
    new_unsup_s = 1'b1;
    case (param_data_type)
      DT_RAW8:  begin new_fmt_s = FMT_RAW8;  new_unsup_s = ~ENABLE_RAW8;  end
      DT_RAW10: begin new_fmt_s = FMT_RAW10; new_unsup_s = ~ENABLE_RAW10; end
      DT_RAW12: begin new_fmt_s = FMT_RAW12; new_unsup_s = ~ENABLE_RAW12; end
      DT_RAW14: begin new_fmt_s = FMT_RAW14; new_unsup_s = ~ENABLE_RAW14; end
      default:  begin new_fmt_s = FMT_RAW8;  new_unsup_s = 1'b1;          end
    endcase
  end

  // A tuser byte restarts the group under the newly presented format
  always_comb begin
    if (s_axi4s_tuser) begin
      eff_fmt_s   = new_fmt_s;
      eff_unsup_s = new_unsup_s;
      eff_cnt_s   = 3'd0;
    end else begin
      eff_fmt_s   = fmt_q;
      eff_unsup_s = unsup_q;
      eff_cnt_s   = cnt_q;
    end
    last_byte_s = (eff_cnt_s == (fmt_bytes(eff_fmt_s) - 3'd1));
    complete_s  = ~eff_unsup_s & last_byte_s;
    xfer_ok_s   = (dcnt_q == 3'd0) || ((dcnt_q == 3'd1) && m_axi4s_tready);
    s_axi4s_tready = run_q & cke & ~(complete_s & ~xfer_ok_s);
    accept_s    = s_axi4s_tvalid & s_axi4s_tready;
    m_hs_s      = m_axi4s_tvalid & m_axi4s_tready;
    lidx_s      = 2'(eff_cnt_s - fmt_pixels(eff_fmt_s));
    msb_n_s     = msb_q;
    lsb_n_s     = lsb_q;
    if (eff_cnt_s < fmt_pixels(eff_fmt_s)) begin
      msb_n_s[eff_cnt_s[1:0]] = s_axi4s_tdata;
    end else begin
      lsb_n_s[lidx_s] = s_axi4s_tdata;
    end
    if (eff_cnt_s == 3'd0) begin
      guser_n_s = s_axi4s_tuser;
    end else begin
      guser_n_s = guser_q | s_axi4s_tuser;
    end
  end

  jelly2_mipi_csi2_raw_extract u_extract (
    .fmt (eff_fmt_s),
    .msb (msb_n_s),
    .lsb (lsb_n_s),
    .pix (raw_s)
  );

  // Next state: drain shifts on each output handshake, a completed group reloads it
  always_comb begin
    fmt_d       = fmt_q;
    unsup_d     = unsup_q;
    cnt_d       = cnt_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    guser_d     = guser_q;
    pix_d       = pix_q;
    dcnt_d      = dcnt_q;
    duser_d     = duser_q;
    dlast_d     = dlast_q;
    err_short_d = 1'b0;
    err_unsup_d = 1'b0;
    if (m_hs_s) begin
      pix_d   = {{DATA_WIDTH{1'b0}}, pix_q[3:1]};
      dcnt_d  = dcnt_q - 3'd1;
      duser_d = 1'b0;
    end else begin
      dcnt_d  = dcnt_q;
    end
    if (accept_s) begin
      if (s_axi4s_tuser) begin
        fmt_d       = new_fmt_s;
        unsup_d     = new_unsup_s;
        err_unsup_d = new_unsup_s;
      end else begin
        unsup_d     = unsup_q;
      end
      if (eff_unsup_s) begin
        cnt_d = 3'd0;
      end else begin
        msb_d   = msb_n_s;
        lsb_d   = lsb_n_s;
        guser_d = guser_n_s;
        if (last_byte_s) begin
          cnt_d = 3'd0;
          for (int k = 0; k < 4; k++) begin
            pix_d[k] = scale_pixel(raw_s[k], eff_fmt_s);
          end
          dcnt_d  = fmt_pixels(eff_fmt_s);
          duser_d = guser_n_s;
          dlast_d = s_axi4s_tlast;
        end else if (s_axi4s_tlast) begin
          cnt_d       = 3'd0;
          err_short_d = 1'b1;
        end else begin
          cnt_d = eff_cnt_s + 3'd1;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset; cke low freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q       <= 1'b0;
      fmt_q       <= FMT_RAW8;
      unsup_q     <= 1'b0;
      cnt_q       <= 3'd0;
      msb_q       <= '0;
      lsb_q       <= '0;
      guser_q     <= 1'b0;
      pix_q       <= '0;
      dcnt_q      <= 3'd0;
      duser_q     <= 1'b0;
      dlast_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_unsup_q <= 1'b0;
    end else if (cke) begin
      run_q       <= 1'b1;
      fmt_q       <= fmt_d;
      unsup_q     <= unsup_d;
      cnt_q       <= cnt_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      guser_q     <= guser_d;
      pix_q       <= pix_d;
      dcnt_q      <= dcnt_d;
      duser_q     <= duser_d;
      dlast_q     <= dlast_d;
      err_short_q <= err_short_d;
      err_unsup_q <= err_unsup_d;
    end
  end

  assign m_axi4s_tvalid        = (dcnt_q != 3'd0);
  assign m_axi4s_tdata         = pix_q[0];
  assign m_axi4s_tuser         = duser_q;
  assign m_axi4s_tlast         = dlast_q & (dcnt_q == 3'd1);
  assign out_error_short       = err_short_q;
  assign out_error_unsupported = err_unsup_q;

endmodule

// File: tb/tb_jelly2_mipi_csi2_rx_raw_unpack.sv
// Randomised scoreboard bench for the CSI-2 RAW unpacker, with a byte-level
// reference model and directed cases for the documented example groups.
module tb_jelly2_mipi_csi2_rx_raw_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cke = 1'b1;
  logic [7:0]  param_data_type = 8'h2a;
  logic        out_error_short, out_error_unsupported;
  logic        s_axi4s_tuser = 1'b0, s_axi4s_tlast = 1'b0, s_axi4s_tvalid = 1'b0;
  logic [7:0]  s_axi4s_tdata = 8'h00;
  logic        s_axi4s_tready;
  logic        m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tvalid;
  logic [9:0]  m_axi4s_tdata;
  logic        m_axi4s_tready = 1'b1;

  jelly2_mipi_csi2_rx_raw_unpack #(.DATA_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .cke(cke), .param_data_type(param_data_type),
    .out_error_short(out_error_short), .out_error_unsupported(out_error_unsupported),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready)
  );

  always #5 clk = ~clk;

  int nchecks = 0, nerrors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int exp_short = 0, exp_unsup = 0, got_short = 0, got_unsup = 0;
  int stalls = 0;
  bit rnd_ready = 1'b0;

  int         m_bits = 8;
  logic [7:0] m_buf[$];
  logic       m_guser = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int type_bits(input logic [7:0] dt);
    case (dt)
      8'h2a:   return 8;
      8'h2b:   return 10;
      8'h2c:   return 12;
      8'h2d:   return 14;
      default: return 0;
    endcase
  endfunction

  function automatic int group_pixels(input int bits);
    return (bits == 8) ? 1 : ((bits == 12) ? 2 : 4);
  endfunction

  function automatic int group_bytes(input int bits);
    int np;
    np = group_pixels(bits);
    return np + (np * (bits - 8)) / 8;
  endfunction

  // Reference model: consume one accepted byte, queue any pixels it completes
  task automatic model_byte(input logic [7:0] d, input logic u, input logic l);
    int np, nb, lb;
    logic [31:0] lsbs, px, sc;
    if (u) begin
      m_bits = type_bits(param_data_type);
      m_buf.delete();
      if (m_bits == 0) exp_unsup++;
    end
    if (m_bits == 0) return;
    if (m_buf.size() == 0) m_guser = u;
    else m_guser = m_guser | u;
    m_buf.push_back(d);
    np = group_pixels(m_bits);
    nb = group_bytes(m_bits);
    lb = m_bits - 8;
    if (m_buf.size() == nb) begin
      lsbs = 32'd0;
      for (int i = np; i < nb; i++) lsbs = lsbs | (32'(m_buf[i]) << (8 * (i - np)));
      for (int k = 0; k < np; k++) begin
        px = (32'(m_buf[k]) << lb) | ((lsbs >> (k * lb)) & ((32'd1 << lb) - 32'd1));
        sc = (((px << m_bits) | px) >> (2 * m_bits - 10)) & 32'h3ff;
        exp_q.push_back({(k == 0) && m_guser, (k == np - 1) && l, sc[9:0]});
      end
      m_buf.delete();
    end else if (l) begin
      m_buf.delete();
      exp_short++;
    end
  endtask

  // Downstream ready: constant 1 or randomly throttled
  always @(posedge clk) begin
    #1;
    if (rnd_ready) m_axi4s_tready = ($urandom_range(0, 3) != 0);
    else m_axi4s_tready = 1'b1;
  end

  logic        hold_v = 1'b0;
  logic [11:0] hold_d = 12'd0;

  // Monitor: scoreboard pop, hold-stability and error pulse counting
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (out_error_short) got_short++;
      if (out_error_unsupported) got_unsup++;
      if (hold_v) check("hold_stable", {19'd0, m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata},
                        {19'd0, 1'b1, hold_d});
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        obs_q.push_back({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata});
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", {20'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, 32'hffffffff);
        end else begin
          check("pixel", {20'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, {20'd0, exp_q.pop_front()});
        end
        hold_v = 1'b0;
      end else begin
        hold_v = m_axi4s_tvalid;
        hold_d = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic u, input logic l);
    int  waitc;
    bit  done;
    waitc = 0;
    done = 1'b0;
    s_axi4s_tdata = d; s_axi4s_tuser = u; s_axi4s_tlast = l; s_axi4s_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axi4s_tready) begin
        model_byte(d, u, l);
        done = 1'b1;
      end else begin
        if (!rnd_ready) stalls++;
        waitc++;
        if (waitc > 1000) begin
          nchecks++; nerrors++;
          $display("FAIL send_timeout: s_tready stuck at 0 for %0d cycles", waitc);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_axi4s_tvalid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    nchecks++;
    if (c >= 3000) begin
      nerrors++;
      $display("FAIL drain_timeout: %0d pixels still expected after %0d cycles", exp_q.size(), c);
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  logic [7:0] stream[1000];
  int n0, a0, b0, s0, u0;

  initial begin
    // reset state
    idle(3);
    @(negedge clk);
    check("reset_s_tready", {31'd0, s_axi4s_tready}, 32'd0);
    check("reset_m_outputs", {19'd0, m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, 32'd0);
    check("reset_errors", {30'd0, out_error_short, out_error_unsupported}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("s_tready_after_reset", {31'd0, s_axi4s_tready}, 32'd1);
    @(posedge clk); #1;

    // RAW8 single byte, one-cycle latency
    n0 = obs_q.size();
    param_data_type = 8'h2a;
    send_byte(8'h80, 1'b1, 1'b0);
    @(negedge clk);
    check("raw8_latency_tvalid", {31'd0, m_axi4s_tvalid}, 32'd1);
    @(posedge clk); #1;
    wait_drain();
    check("raw8_count", obs_q.size() - n0, 32'd1);
    if (obs_q.size() > n0) check("raw8_pixel", {20'd0, obs_q[n0]}, {20'd0, 1'b1, 1'b0, 10'h202});

    // RAW10 documented group
    n0 = obs_q.size();
    param_data_type = 8'h2b;
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0);
    send_byte(8'hE4, 1'b0, 1'b1);
    wait_drain();
    check("raw10_count", obs_q.size() - n0, 32'd4);
    if (obs_q.size() >= n0 + 4) begin
      check("raw10_p0", {20'd0, obs_q[n0]},     {20'd0, 2'b10, 10'h048});
      check("raw10_p1", {20'd0, obs_q[n0 + 1]}, {20'd0, 2'b00, 10'h0D1});
      check("raw10_p2", {20'd0, obs_q[n0 + 2]}, {20'd0, 2'b00, 10'h15A});
      check("raw10_p3", {20'd0, obs_q[n0 + 3]}, {20'd0, 2'b01, 10'h1E3});
    end

    // RAW12 documented group
    n0 = obs_q.size();
    param_data_type = 8'h2c;
    send_byte(8'hAB, 1'b1, 1'b0);
    send_byte(8'hCD, 1'b0, 1'b0);
    send_byte(8'h21, 1'b0, 1'b1);
    wait_drain();
    check("raw12_count", obs_q.size() - n0, 32'd2);
    if (obs_q.size() >= n0 + 2) begin
      check("raw12_p0", {20'd0, obs_q[n0]},     {20'd0, 2'b10, 10'h2AC});
      check("raw12_p1", {20'd0, obs_q[n0 + 1]}, {20'd0, 2'b01, 10'h334});
    end

    // RAW10 short line then a good group
    n0 = obs_q.size(); s0 = got_short;
    param_data_type = 8'h2b;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    wait_drain();
    check("short_pulse", got_short - s0, 32'd1);
    check("short_no_pixels", obs_q.size() - n0, 32'd0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0);
    send_byte(8'hE4, 1'b0, 1'b1);
    wait_drain();
    check("after_short_count", obs_q.size() - n0, 32'd4);
    if (obs_q.size() >= n0 + 4) check("after_short_p3", {20'd0, obs_q[n0 + 3]}, {20'd0, 2'b01, 10'h1E3});

    // Unsupported frame, mid-frame param change ignored
    n0 = obs_q.size(); u0 = got_unsup;
    param_data_type = 8'h30;
    send_byte(8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) param_data_type = 8'h2b;
      send_byte(8'($urandom), 1'b0, (i == 8));
    end
    wait_drain();
    check("unsup_pulse", got_unsup - u0, 32'd1);
    check("unsup_no_pixels", obs_q.size() - n0, 32'd0);
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h56, 1'b0, 1'b0);
    send_byte(8'h78, 1'b0, 1'b0);
    send_byte(8'hE4, 1'b0, 1'b1);
    wait_drain();
    check("unsup_recover_count", obs_q.size() - n0, 32'd4);
    if (obs_q.size() >= n0 + 4) check("unsup_recover_p0", {20'd0, obs_q[n0]}, {20'd0, 2'b10, 10'h048});

    // Reset mid-group drops it; format returns to RAW8
    n0 = obs_q.size();
    send_byte(8'h9A, 1'b1, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b0);
    reset = 1'b1;
    m_buf.delete(); m_bits = 8;
    idle(2);
    reset = 1'b0;
    idle(3);
    check("reset_mid_no_pixels", obs_q.size() - n0, 32'd0);
    send_byte(8'h80, 1'b0, 1'b0);
    wait_drain();
    check("reset_fmt_raw8", {20'd0, obs_q[obs_q.size() - 1]}, {20'd0, 2'b00, 10'h202});

    // RAW10 full rate, then the same stream under random backpressure
    for (int i = 0; i < 1000; i++) stream[i] = 8'($urandom);
    param_data_type = 8'h2b;
    for (int pass = 0; pass < 2; pass++) begin
      rnd_ready = (pass == 1);
      stalls = 0;
      if (pass == 0) a0 = obs_q.size(); else b0 = obs_q.size();
      for (int i = 0; i < 1000; i++) send_byte(stream[i], (i == 0), (i % 100 == 99));
      wait_drain();
      if (pass == 0) begin
        check("fullrate_stalls", stalls, 32'd0);
        check("fullrate_count", obs_q.size() - a0, 32'd800);
      end else begin
        check("backpressure_count", obs_q.size() - b0, 32'd800);
      end
    end
    for (int i = 0; i < 800; i++) begin
      if (b0 + i < obs_q.size()) check("stream_identical", {20'd0, obs_q[b0 + i]}, {20'd0, obs_q[a0 + i]});
    end

    // Random mixed frames with short lines, gaps and backpressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int t, nb, nl, ng, total;
      t = $urandom_range(0, 4);
      param_data_type = (t == 4) ? 8'h2e : 8'(8'h2a + t);
      nb = (t == 4) ? 5 : group_bytes(type_bits(param_data_type));
      nl = $urandom_range(1, 3);
      for (int ln = 0; ln < nl; ln++) begin
        ng = $urandom_range(1, 6);
        total = ng * nb;
        if (nb > 1 && $urandom_range(0, 4) == 0) total = total - $urandom_range(1, nb - 1);
        for (int i = 0; i < total; i++) begin
          send_byte(8'($urandom), (ln == 0 && i == 0), (i == total - 1));
          if ($urandom_range(0, 5) == 0) idle(1);
        end
      end
    end
    wait_drain();
    rnd_ready = 1'b0;
    idle(3);

    check("short_total", got_short, exp_short);
    check("unsup_total", got_unsup, exp_unsup);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
